oka_64bit_seq_ctrl: RTL
=======================

OKA_64BIT_SEQ_CTRL -- requirements
Module: oka_64bit_seq_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 1, meaning the fixed latency in cycles of the shared 32-bit OKA multiplier; legal range 0..4.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst_n  input  1  Reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  A 64x64 carry-less multiply request is present.
REQ-005 in_ready  output  1  The controller accepts a request this cycle.
REQ-006 a, b  input  64 each  Operand polynomials, sampled on the accept edge.
REQ-007 mul_valid  output  1  An operand pair is driven to the shared multiplier.
REQ-008 mul_a, mul_b  output  32 each  Operand pair for the shared multiplier.
REQ-009 mul_y  input  63  Multiplier product for the pair driven MUL_LAT cycles earlier.
REQ-010 out_valid  output  1  Result y is valid.
REQ-011 out_ready  input  1  The consumer takes y.
REQ-012 y  output  127  64x64 GF(2) product.

Function
REQ-013 States: IDLE, ISS0, ISS1, ISS2, WAIT, COMB, DONE; in_ready = (state==IDLE).
REQ-014 Accept = in_valid & in_ready; on the accept edge, latch al=a[31:0], ah=a[63:32], bl=b[31:0], bh=b[63:32], and go IDLE->ISS0.
REQ-015 ISS0 drives (al,bl); ISS1 drives (ah,bh); ISS2 drives (al^ah, bl^bh); mul_valid=1 only in ISSx, with mul_a/mul_b=0 otherwise.
REQ-016 Capture mul_y into z0/z2/z1 at the end of the cycle exactly MUL_LAT cycles after the ISS0/ISS1/ISS2 cycle, using a 3-entry valid/tag shift pipe of depth MUL_LAT.
REQ-017 With MUL_LAT=0, capture in the same ISSx cycle.
REQ-018 WAIT lasts until the z1 capture cycle, inclusive; the last capture transitions to COMB.
REQ-019 COMB registers y = (z2<<64) ^ ((z0^z1^z2)<<32) ^ z0, XOR only, no carries, bits above 126 dropped, then goes to DONE.
REQ-020 DONE holds out_valid=1 and y stable until out_ready=1, then goes DONE->IDLE.
REQ-021 Timing: accept edge = end of cycle 0; ISS0/1/2 in cycles 1/2/3; out_valid first high in cycle 5+MUL_LAT.
REQ-022 Back-to-back operation: a new request may be accepted no earlier than the cycle after out handshake; throughput is one result per 6+MUL_LAT cycles.
REQ-023 in_valid during non-IDLE states is ignored; operand changes after accept have no effect.
REQ-024 out_ready while out_valid=0 has no effect.

Reset
REQ-025 rst_n low: state=IDLE, out_valid=0, mul_valid=0, y=0, z0/z1/z2=0, tag pipe cleared, operand latches=0, asynchronously.
REQ-026 Reset mid-operation discards the operation; any mul_y arriving after reset release is ignored.
REQ-027 in_ready=1 in the first cycle after reset release.

Configuration
REQ-028 Macro OKA_SEQ_PERF_EN defined: adds output perf_cnt [15:0], incremented on each out handshake, saturating at 0xFFFF, reset to 0.
REQ-029 Macro OKA_SEQ_PERF_EN undefined: no perf_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-030 MUL_LAT=1, a=0x3, b=0x3, out_ready=1 -> y=0x5 with out_valid high in cycle 6 after accept.
REQ-031 a=0x8000000000000000, b=0x8000000000000000 -> y=0x4000...0 (bit 126 only); a=b=0xFFFFFFFFFFFFFFFF -> y equals the software clmul reference.
REQ-032 Hold out_ready=0 for 10 cycles -> out_valid and y stable, in_ready=0, then one handshake -> IDLE.
REQ-033 MUL_LAT swept 0..4 with 1000 random operands -> all results match clmul, and mul_valid is high exactly 3 cycles per operation.
REQ-034 Assert rst_n low in ISS1, release, accept a=1, b=1 -> y=1 and no stale capture.
REQ-035 With OKA_SEQ_PERF_EN, 5 completed operations -> perf_cnt=5; reset -> perf_cnt=0.

Source files
------------

// File: rtl/oka_64bit_seq_ctrl.sv
// Sequential 64x64 GF(2) multiplier controller: three passes through one shared 32-bit
// OKA multiplier (Karatsuba), then XOR recombination. Optional perf counter: OKA_SEQ_PERF_EN.
module oka_64bit_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         mul_valid,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  input  logic [62:0]  mul_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [126:0] y
`ifdef OKA_SEQ_PERF_EN
  ,
  output logic [15:0]  perf_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, ISS0, ISS1, ISS2, WAIT, COMB, DONE} state_t;

  // Tag of the partial product travelling with each issued pair.
  localparam logic [1:0] TAG_Z0 = 2'd0;
  localparam logic [1:0] TAG_Z2 = 2'd1;
  localparam logic [1:0] TAG_Z1 = 2'd2;

  state_t       state, state_nxt;
  logic [31:0]  al, ah, bl, bh;
  logic [62:0]  z0, z1, z2;
  logic         iss_vld;
  logic [1:0]   iss_tag;
  logic         cap_vld;
  logic [1:0]   cap_tag;
  logic         accept;
  logic         last_cap;

  function automatic logic [126:0] kara_comb(input logic [62:0] lo,
                                             input logic [62:0] mid,
                                             input logic [62:0] hi);
    logic [62:0] m;
    m = lo ^ mid ^ hi;
    return {hi, 64'b0} ^ {32'b0, m, 32'b0} ^ {64'b0, lo};
  endfunction

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_cap  = cap_vld && (cap_tag == TAG_Z1);

  always_comb begin
    iss_vld = 1'b0;
    iss_tag = TAG_Z0;
    mul_a   = '0;
    mul_b   = '0;
    case (state)
      ISS0: begin
        iss_vld = 1'b1;
        iss_tag = TAG_Z0;
        mul_a   = al;
        mul_b   = bl;
      end
      ISS1: begin
        iss_vld = 1'b1;
        iss_tag = TAG_Z2;
        mul_a   = ah;
        mul_b   = bh;
      end
      ISS2: begin
        iss_vld = 1'b1;
        iss_tag = TAG_Z1;
        mul_a   = al ^ ah;
        mul_b   = bl ^ bh;
      end
      default: ;
    endcase
  end

  assign mul_valid = iss_vld;

  // Issue -> capture alignment: tag pipe matching the multiplier latency.
  generate
    if (MUL_LAT == 0) begin : g_nopipe
      assign cap_vld = iss_vld;
      assign cap_tag = iss_tag;
    end else begin : g_pipe
      logic [MUL_LAT-1:0] cap_vld_p;
      logic [1:0]         cap_tag_p [MUL_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cap_vld_p <= '0;
          for (int i = 0; i < MUL_LAT; i++) cap_tag_p[i] <= '0;
        end else begin
          cap_vld_p[0] <= iss_vld;
          cap_tag_p[0] <= iss_tag;
          for (int i = 1; i < MUL_LAT; i++) begin
            cap_vld_p[i] <= cap_vld_p[i-1];
            cap_tag_p[i] <= cap_tag_p[i-1];
          end
        end
      end

      assign cap_vld = cap_vld_p[MUL_LAT-1];
      assign cap_tag = cap_tag_p[MUL_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ISS0;
      ISS0:    state_nxt = ISS1;
      ISS1:    state_nxt = ISS2;
      ISS2:    state_nxt = last_cap ? COMB : WAIT;
      WAIT:    if (last_cap) state_nxt = COMB;
      COMB:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, partial-product capture and recombination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al <= '0;
      ah <= '0;
      bl <= '0;
      bh <= '0;
      z0 <= '0;
      z1 <= '0;
      z2 <= '0;
      y  <= '0;
    end else begin
      if (accept) begin
        al <= a[31:0];
        ah <= a[63:32];
        bl <= b[31:0];
        bh <= b[63:32];
      end
      if (cap_vld) begin
        case (cap_tag)
          TAG_Z0:  z0 <= mul_y;
          TAG_Z2:  z2 <= mul_y;
          default: z1 <= mul_y;
        endcase
      end
      if (state == COMB) y <= kara_comb(z0, z1, z2);
    end
  end

`ifdef OKA_SEQ_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       perf_cnt <= '0;
    else if (out_valid && out_ready)  perf_cnt <= sat_inc(perf_cnt);
  end
`endif

endmodule
